button_reader: RTL and testbench

- Input-side counterpart of the 4-LED one-hot driver: reads four active-high push buttons and encodes them into one 2-bit key index.
- Per button: synchronise, then debounce. A press FSM classifies each press as short, long or multi-key.
- Emits single-cycle key events to the board's control logic, e.g. to select or step the LED pattern.
- Board clock 50 MHz.

---
 rtl/board_pkg.sv | 36 +++
 rtl/btn_debounce.sv | 48 ++++
 rtl/button_reader.sv | 145 ++++++++++++++
 tb/tb_button_reader.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared board-level types and constants for the push-button front end.
package board_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LONG,
        WAIT_RELEASE
    } key_state_e;

    localparam logic [1:0] KEY_1 = 2'd0;
    localparam logic [1:0] KEY_2 = 2'd1;
    localparam logic [1:0] KEY_3 = 2'd2;
    localparam logic [1:0] KEY_4 = 2'd3;

    localparam int unsigned DEBOUNCE_10MS = 500000;
    localparam int unsigned HOLD_1S       = 50000000;

    // True when two or more bits are set.
    function automatic logic multi_hot(input logic [3:0] v);
        return (v & (v - 4'd1)) != '0;
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = KEY_1;
        case (v)
            4'b0010: idx = KEY_2;
            4'b0100: idx = KEY_3;
            4'b1000: idx = KEY_4;
            default: idx = KEY_1;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability counter for one raw button.
module btn_debounce
    import board_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = deb_q;

endmodule

// File: rtl/button_reader.sv
// Debounces four push buttons and classifies presses as short, long or multi-key,
// emitting registered single-cycle key events.
module button_reader
    import board_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int unsigned LONG_CYCLES     = HOLD_1S
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_1,
    input  logic       btn_2,
    input  logic       btn_3,
    input  logic       btn_4,
    output logic [3:0] btn_state,
    output logic       key_valid,
    output logic [1:0] key_idx,
    output logic       key_long,
    output logic       key_multi
);

    localparam int unsigned CNT_W = $clog2(LONG_CYCLES + 1);

    logic [3:0]       raw;
    logic [3:0]       deb;

    key_state_e       state_q, state_d;
    logic [1:0]       cur_q, cur_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             valid_q, valid_d;
    logic [1:0]       idx_q, idx_d;
    logic             long_q, long_d;
    logic             multi_q, multi_d;

    logic             other_down;
    logic             hold_done;

    assign raw = {btn_4, btn_3, btn_2, btn_1};

    for (genvar g = 0; g < 4; g++) begin : g_deb
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .reset(reset),
            .raw  (raw[g]),
            .level(deb[g])
        );
    end

    assign other_down = (deb & ~(4'b0001 << cur_q)) != '0;
    assign hold_done  = hold_q == CNT_W'(LONG_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cur_q   <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            long_q  <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            long_q  <= long_d;
            multi_q <= multi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (deb != '0) begin
                    if (multi_hot(deb)) begin
                        state_d = WAIT_RELEASE;
                    end else begin
                        cur_d   = onehot_idx(deb);
                        hold_d  = '0;
                        state_d = PRESSED;
                    end
                end
            end
            PRESSED: begin
                // A second key wins over release and over the long-hold timeout.
                if (other_down) begin
                    state_d = WAIT_RELEASE;
                end else if (deb == '0) begin
                    state_d = IDLE;
                end else if (hold_done) begin
                    state_d = LONG;
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            LONG, WAIT_RELEASE: begin
                if (deb == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d = 1'b0;
        multi_d = 1'b0;
        idx_d   = idx_q;
        long_d  = long_q;
        case (state_q)
            IDLE: begin
                if (multi_hot(deb)) begin
                    multi_d = 1'b1;
                end
            end
            PRESSED: begin
                if (other_down) begin
                    multi_d = 1'b1;
                end else if (deb == '0) begin
                    valid_d = 1'b1;
                    idx_d   = cur_q;
                    long_d  = 1'b0;
                end else if (hold_done) begin
                    valid_d = 1'b1;
                    idx_d   = cur_q;
                    long_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign btn_state = deb;
    assign key_valid = valid_q;
    assign key_idx   = idx_q;
    assign key_long  = long_q;
    assign key_multi = multi_q;

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader with short debounce and hold times.
module tb_button_reader;

    localparam int unsigned DEB = 4;
    localparam int unsigned LNG = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_1, btn_2, btn_3, btn_4;
    logic [3:0] btn_state;
    logic       key_valid;
    logic [1:0] key_idx;
    logic       key_long;
    logic       key_multi;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_multi = 0;
    int n_both  = 0;

    typedef struct {
        logic       rst;
        logic [3:0] btn;
        logic [3:0] st;
        logic       v;
        logic [1:0] idx;
        logic       lng;
        logic       mul;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    button_reader #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LNG)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_1    (btn_1),
        .btn_2    (btn_2),
        .btn_3    (btn_3),
        .btn_4    (btn_4),
        .btn_state(btn_state),
        .key_valid(key_valid),
        .key_idx  (key_idx),
        .key_long (key_long),
        .key_multi(key_multi)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        if (key_valid) n_valid++;
        if (key_multi) n_multi++;
        if (key_valid && key_multi) n_both++;
    endtask

    task automatic set_btn(input logic [3:0] b);
        {btn_4, btn_3, btn_2, btn_1} = b;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int n, input logic rst, input logic [3:0] btn, input logic [3:0] st,
                       input logic v, input logic [1:0] idx, input logic lng, input logic mul);
        vec_t r;
        r.rst = rst; r.btn = btn; r.st = st; r.v = v; r.idx = idx; r.lng = lng; r.mul = mul;
        repeat (n) tbl.push_back(r);
    endtask

    task automatic wait_state(input int b, input int bound, output int n);
        n = -1;
        for (int k = 1; k <= bound; k++) begin
            tick();
            if (btn_state[b]) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic wait_valid(input int bound, output int n);
        n = -1;
        for (int k = 1; k <= bound; k++) begin
            tick();
            if (key_valid) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int t;
        reset = 1'b1;
        set_btn(4'b0000);

        // Each row: inputs applied before an edge, outputs expected just after it.
        add(3, 1, 4'b0001, 4'b0000, 0, 0, 0, 0);
        add(5, 0, 4'b0001, 4'b0000, 0, 0, 0, 0);
        add(1, 0, 4'b0001, 4'b0001, 0, 0, 0, 0);
        add(5, 0, 4'b0000, 4'b0001, 0, 0, 0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        add(1, 0, 4'b0000, 4'b0000, 1, 0, 0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        add(1, 0, 4'b0010, 4'b0000, 0, 0, 0, 0);
        add(1, 0, 4'b0010, 4'b0000, 0, 0, 0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        add(1, 0, 4'b0010, 4'b0000, 0, 0, 0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        add(2, 0, 4'b0010, 4'b0000, 0, 0, 0, 0);
        add(3, 0, 4'b0010, 4'b0000, 0, 0, 0, 0);
        add(7, 0, 4'b0010, 4'b0010, 0, 0, 0, 0);
        add(5, 0, 4'b0000, 4'b0010, 0, 0, 0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        add(1, 0, 4'b0000, 4'b0000, 1, 1, 0, 0);
        add(1, 0, 4'b0000, 4'b0000, 0, 1, 0, 0);

        foreach (tbl[i]) begin
            reset = tbl[i].rst;
            set_btn(tbl[i].btn);
            tick();
            check($sformatf("vec%0d btn_state", i), int'(btn_state), int'(tbl[i].st));
            check($sformatf("vec%0d key_valid", i), int'(key_valid), int'(tbl[i].v));
            check($sformatf("vec%0d key_idx", i), int'(key_idx), int'(tbl[i].idx));
            check($sformatf("vec%0d key_long", i), int'(key_long), int'(tbl[i].lng));
            check($sformatf("vec%0d key_multi", i), int'(key_multi), int'(tbl[i].mul));
        end

        // Long press on btn_4: event arrives one entry cycle plus LNG after the debounced rise.
        n_valid = 0; n_multi = 0;
        set_btn(4'b1000);
        wait_state(3, 20, t);
        check("long_deb_rise", t, 6);
        wait_valid(40, t);
        check("long_latency", t, 21);
        check("long_idx", int'(key_idx), 3);
        check("long_flag", int'(key_long), 1);
        repeat (13) tick();
        set_btn(4'b0000);
        repeat (15) tick();
        check("long_valid_count", n_valid, 1);
        check("long_multi_count", n_multi, 0);

        // Simultaneous btn_1+btn_2: multi only, idx/long retained.
        n_valid = 0; n_multi = 0;
        set_btn(4'b0011);
        repeat (15) tick();
        set_btn(4'b0000);
        repeat (15) tick();
        check("simul_multi_count", n_multi, 1);
        check("simul_valid_count", n_valid, 0);
        check("simul_idx_kept", int'(key_idx), 3);
        check("simul_long_kept", int'(key_long), 1);

        // Sequential multi: btn_1 then btn_3.
        n_valid = 0; n_multi = 0;
        set_btn(4'b0001);
        wait_state(0, 20, t);
        check("seq_deb_rise", t, 6);
        repeat (5) tick();
        set_btn(4'b0101);
        repeat (15) tick();
        set_btn(4'b0000);
        repeat (15) tick();
        check("seq_multi_count", n_multi, 1);
        check("seq_valid_count", n_valid, 0);
        n_valid = 0; n_multi = 0;
        set_btn(4'b0001);
        repeat (10) tick();
        set_btn(4'b0000);
        repeat (15) tick();
        check("seq_after_valid_count", n_valid, 1);
        check("seq_after_idx", int'(key_idx), 0);
        check("seq_after_long", int'(key_long), 0);
        check("seq_after_multi_count", n_multi, 0);

        // Reset mid-hold with btn_3 kept down.
        set_btn(4'b0100);
        wait_state(2, 20, t);
        check("rst_deb_rise", t, 6);
        repeat (11) tick();
        n_valid = 0; n_multi = 0;
        reset = 1'b1;
        tick();
        check("rst_btn_state", int'(btn_state), 0);
        tick();
        check("rst_valid", int'(key_valid), 0);
        check("rst_idx", int'(key_idx), 0);
        reset = 1'b0;
        wait_valid(60, t);
        check("rst_relatch_latency", t, 27);
        check("rst_relatch_idx", int'(key_idx), 2);
        check("rst_relatch_long", int'(key_long), 1);
        check("rst_relatch_valid_count", n_valid, 1);
        set_btn(4'b0000);
        repeat (15) tick();
        check("rst_multi_count", n_multi, 0);
        check("never_both", n_both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
